// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall/flush sequencer and the 5-stage pipeline.
// The pipeline side (master) drives hazard/memory status; the sequencer (slave) drives the controls.
interface pipeline_stall_ctrl_if;
  logic        mem_req;
  logic        mem_ready;
  logic        branch_taken;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RD;
  logic [4:0]  IF_ID_RS1;
  logic [4:0]  IF_ID_RS2;

  logic        PC_en;
  logic        IF_ID_en;
  logic        ID_EX_en;
  logic        EX_MEM_en;
  logic        MEM_WB_en;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_bubble;
  logic        mem_start;
  logic        mem_error;
  logic [31:0] stall_count;

  modport master (
    output mem_req, mem_ready, branch_taken, ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
    input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
    input  MEM_WB_bubble, mem_start, mem_error, stall_count
  );

  modport slave (
    input  mem_req, mem_ready, branch_taken, ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
    output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
    output MEM_WB_bubble, mem_start, mem_error, stall_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: memory wait with timeout, taken-branch flush, load-use bubble.
// Define PIPELINE_STALL_CNT_EN to build the saturating stalled-cycle counter.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [7:0] TimeoutW = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;

  logic mem_stall, timeout_rel, load_use;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_start;

  assign load_use = bus.ID_EX_MemRead && (bus.ID_EX_RD != 5'd0) &&
                    ((bus.ID_EX_RD == bus.IF_ID_RS1) || (bus.ID_EX_RD == bus.IF_ID_RS2));

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    mem_stall   = 1'b0;
    timeout_rel = 1'b0;
    mem_start   = 1'b0;

    unique case (state_q)
      StRun: begin
        mem_start = bus.mem_req;
        if (bus.mem_req && !bus.mem_ready) begin
          mem_stall = 1'b1;
          state_d   = StMemWait;
          wcnt_d    = 8'd1;
        end
      end
      StMemWait: begin
        if (bus.mem_ready) begin
          state_d = StRun;
          wcnt_d  = 8'd0;
        end else if (wcnt_q < TimeoutW) begin
          mem_stall = 1'b1;
          wcnt_d    = wcnt_q + 8'd1;
        end else begin
          // Abandon the access: release the pipeline but suppress writeback.
          timeout_rel = 1'b1;
          err_d       = 1'b1;
          state_d     = StRun;
          wcnt_d      = 8'd0;
        end
      end
      default: state_d = StRun;
    endcase

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = mem_stall | timeout_rel;

    // EX is frozen during a memory stall, so hazards are re-evaluated on release.
    if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (bus.branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    if (reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      mem_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.PC_en         = pc_en;
  assign bus.IF_ID_en      = if_id_en;
  assign bus.ID_EX_en      = id_ex_en;
  assign bus.EX_MEM_en     = ex_mem_en;
  assign bus.MEM_WB_en     = mem_wb_en;
  assign bus.IF_ID_flush   = if_id_flush;
  assign bus.ID_EX_flush   = id_ex_flush;
  assign bus.MEM_WB_bubble = mem_wb_bubble;
  assign bus.mem_start     = mem_start;
  assign bus.mem_error     = reset ? 1'b0 : err_q;

`ifdef PIPELINE_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_count = reset ? 32'd0 : cnt_q;
`else
  assign bus.stall_count = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates three hazard sources: a multi-cycle data-memory access (with ready handshake and timeout), a taken branch, and a load-use dependency.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before an access is abandoned. Legal range 1..255.

Ports:
- clk  in  1  clock; controller state updates on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  EX/MEM holds a valid load or store (MemRead|MemWrite).
- mem_ready  in  1  data memory completes the current access this cycle.
- branch_taken  in  1  EX stage resolved a taken branch/jump.
- ID_EX_MemRead  in  1  instruction in ID/EX is a load.
- ID_EX_RD  in  5  destination register of ID/EX.
- IF_ID_RS1, IF_ID_RS2  in  5  source registers of the instruction in IF/ID.
- PC_en  out  1  PC update enable.
- IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1  pipeline register load enables.
- IF_ID_flush  out  1  load NOP into IF/ID.
- ID_EX_flush  out  1  clear control bits entering ID/EX (bubble).
- MEM_WB_bubble  out  1  force RegWrite=0 and MemtoReg=0 into MEM/WB.
- mem_start  out  1  one-cycle access strobe to data memory.
- mem_error  out  1  sticky; an access hit MEM_TIMEOUT.
- stall_count  out  32  stalled-cycle counter (see Configuration).

## Operation
- Two-state FSM: RUN and MEM_WAIT, plus a wait counter `wcnt` (8 bits).
- **RUN**
  - mem_start = mem_req.
  - mem_req=1, mem_ready=0: memory stall this cycle. PC_en, IF_ID_en, ID_EX_en and EX_MEM_en are 0; MEM_WB_bubble=1; MEM_WB_en=1. Next state MEM_WAIT, wcnt←1.
  - mem_req=1, mem_ready=1: zero-wait access. No stall; stay in RUN.
- **MEM_WAIT**
  - mem_start=0.
  - mem_ready=0 and wcnt<MEM_TIMEOUT: same stall outputs as above; wcnt←wcnt+1.
  - mem_ready=1: release. Outputs are as in RUN with no memory stall (MEM_WB_bubble=0, so the load data is written back). Next state RUN.
  - mem_ready=0 and wcnt==MEM_TIMEOUT: release with MEM_WB_bubble=1 (no writeback). mem_error←1. Next state RUN.
- **Hazard priority when not memory-stalled:** branch > load-use.
  - branch_taken=1: IF_ID_flush=1, ID_EX_flush=1; all enables 1.
  - Load-use: ID_EX_MemRead=1 and ID_EX_RD≠0 and (ID_EX_RD==IF_ID_RS1 or ID_EX_RD==IF_ID_RS2).
    - Response: PC_en=0, IF_ID_en=0, ID_EX_flush=1; the other enables stay 1.
    - Lasts one cycle by construction: the bubble removes the condition.
  - No hazard: all enables 1, all flushes 0.
- **During a memory stall:** branch_taken and the load-use condition are ignored and all flushes are 0. EX is frozen, so either condition is re-evaluated on release.
- **mem_error:** cleared only by reset.

## Timing
- Outputs are combinational from state and current inputs (zero latency). They must settle before the pipeline registers' negedge capture.
- FSM, wcnt, mem_error and stall_count update on posedge clk.
- Memory stall length = cycles until mem_ready, bounded by MEM_TIMEOUT+1 stalled cycles.
- **Reset asserted (asynchronous):**
  - state→RUN, wcnt→0, mem_error→0, stall_count→0.
  - All outputs are forced to 0 while reset is high; the pipeline is frozen.
- **Reset mid-MEM_WAIT:** the access is abandoned without error; on release the controller starts in RUN.
- **mem_ready=1 while mem_req=0:** ignored.

## Configuration
- Macro: `PIPELINE_STALL_CNT_EN`.
- **Defined:** stall_count increments on each posedge where PC_en=0 and reset=0. It saturates at 32'hFFFF_FFFF.
- **Undefined:** stall_count is tied to 0 and no counter flops are built. The port remains present.

## Test plan
- **Load-use:** ID_EX_MemRead=1, ID_EX_RD=5, IF_ID_RS2=5 → exactly 1 cycle with PC_en=0, IF_ID_en=0, ID_EX_flush=1. With ID_EX_RD=0 → no stall.
- **Branch vs load-use:** branch_taken=1 together with the load-use condition → IF_ID_flush=1, ID_EX_flush=1, PC_en=1.
- **Memory wait:** mem_req=1 with mem_ready rising after 3 cycles → mem_start pulses once. Expect 3 cycles of EX_MEM_en=0 and MEM_WB_bubble=1, then 1 release cycle with all enables 1 and MEM_WB_bubble=0. With the macro, stall_count=3.
- **Timeout:** MEM_TIMEOUT=4, mem_ready held 0 → 5 stalled cycles. The last cycle has all enables 1 and MEM_WB_bubble=1; mem_error=1 afterwards and stays set.
- **Zero-wait memory:** mem_req=1, mem_ready=1 in the same cycle → mem_start=1, no stall, state stays RUN.
- **Reset mid-operation:** reset pulsed in MEM_WAIT → all outputs 0 immediately, mem_error=0, stall_count=0. After release the FSM is in RUN.
